id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register combined with load-use hazard detection for the 5-stage RV32I core.
- Sits between decode and EX, directly upstream of the forwarding unit: it produces the id_ex_rs1/id_ex_rs2/id_ex_rd and control fields that forwarding and the ALU consume.
- Inserts bubbles on load-use hazards, stalls PC and IF/ID, squashes on taken branch/jump flush, and freezes on data-memory stall.

Parameters:
- XLEN, 32, datapath width.
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..3.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2.
- id_rs1_data, id_rs2_data, id_imm  in  XLEN each  operands and immediate.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch, id_jump  in  1 each  decoded control.
- id_alu_op  in  4  ALU operation.
- id_funct3  in  3  funct3 field.
- ex_flush  in  1  taken branch/jump resolved in EX.
- mem_stall  in  1  data memory busy; freeze the whole pipe.
- id_ex_*  out  same widths  registered copies of every id_* input above, plus id_ex_valid.
- pc_write_en  out  1  PC may update.
- if_id_write_en  out  1  IF/ID may update.
- bubble_count, flush_count  out  CNT_W each  saturating event counters.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All id_ex_* outputs become 0, including id_ex_valid and id_ex_rd=0; reg_write=0 so forwarding never matches.
  - FSM goes to RUN, bubble counter goes to 0, both perf counters go to 0.
  - pc_write_en=1 and if_id_write_en=1 while in RUN.
- Hazard detect (combinational):
  - hz = id_valid and id_ex_valid and id_ex_mem_read and id_ex_rd!=0 and ((id_uses_rs1 and id_rs1==id_ex_rd) or (id_uses_rs2 and id_rs2==id_ex_rd)).
- FSM states: RUN and LU_STALL. Register bcnt is 2 bits wide.
- Priority each cycle: reset > mem_stall > ex_flush > hazard > normal.
- mem_stall=1:
  - All id_ex_* hold their values; FSM and bcnt hold; counters hold.
  - pc_write_en=0 and if_id_write_en=0.
  - ex_flush is ignored; EX keeps the branch and re-asserts the flush after the stall ends.
- ex_flush=1 (and no mem_stall):
  - Load a bubble: id_ex_valid=0 and every control bit plus id_alu_op go to 0. Data fields are don't-care; drive 0.
  - FSM goes to RUN and bcnt to 0; any pending load-use stall is aborted.
  - flush_count increments.
  - pc_write_en=1 and if_id_write_en=1 so the redirect target is fetched.
- RUN, hz=1:
  - Load a bubble; bubble_count increments.
  - pc_write_en=0 and if_id_write_en=0 in the same cycle.
  - If LOAD_USE_BUBBLES>1, go to LU_STALL with bcnt=LOAD_USE_BUBBLES-1; otherwise stay in RUN.
- LU_STALL:
  - Load a bubble each cycle; bubble_count increments.
  - Hold PC and IF/ID (both enables 0); bcnt decrements.
  - When bcnt reaches 1, return to RUN on that edge.
  - The stalled instruction is then captured normally on the next edge.
- RUN, no hazard: capture all id_* into id_ex_*; id_ex_valid=id_valid. Latency is 1 cycle.
- Outputs: pc_write_en and if_id_write_en are combinational from state, hz, mem_stall and ex_flush. All id_ex_* outputs are pure registers.
- A bubble never re-triggers hz, because id_ex_valid=0.
- Counters saturate at all-ones and do not wrap.
- If ex_flush and hz occur together, flush wins: no stall, one bubble, only flush_count increments.

Decomposition:
- Shared package pipeline_pkg holds:
  - ALU op encodings.
  - ex_ctrl_t struct: reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, alu_op, funct3.
  - Constant CTRL_BUBBLE = all-zero.
  - FSM state enum.
- One natural sub-module: load_use_detect, the combinational hz term. Reused later for multi-cycle loads.
- Counters stay inline.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with id_valid=1 and id_reg_write=1 -> all id_ex_* are 0; pc_write_en=1; both counters 0.
- Back-to-back ALU: id_valid=1, id_rd=5, id_reg_write=1 -> next edge id_ex_rd=5 and id_ex_reg_write=1; no stall.
- Load-use with LOAD_USE_BUBBLES=1: lw x5 in EX (id_ex_mem_read=1, id_ex_rd=5), ID add x6,x5,x7 -> one cycle with pc_write_en=0 and if_id_write_en=0; id_ex_valid=0 next edge; add captured the edge after; bubble_count=1.
- Load-use with LOAD_USE_BUBBLES=3: same stimulus -> 3 consecutive bubbles and 3 stall cycles; bubble_count=3. Repeat with ex_flush in the 2nd bubble cycle -> stall aborts; enables go to 1 that cycle; flush_count=1.
- mem_stall: assert for 4 cycles mid-stream with ex_flush=1 in cycle 2 -> id_ex_* unchanged; enables 0; flush_count unchanged. After release, ex_flush=1 -> bubble loaded and flush_count=1.
- x0 and unused source: lw x0 followed by a read of x0 -> no stall. lw x5 followed by lui x5 (id_uses_rs1=0, id_rs1 field=5) -> no stall.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: ALU op encodings, the EX control bundle and the
// load-use stall state encoding used by the ID/EX register.
package pipeline_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
    logic [2:0] funct3;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic {
    ST_RUN,
    ST_LU_STALL
  } lu_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard term: the instruction in ID reads the
// destination of a load currently sitting in EX.
module load_use_detect (
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       hz
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  assign hz      = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0)
                   && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash,
// memory-stall freeze and saturating bubble/flush event counters.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            id_alu_src,
  input  logic            id_branch,
  input  logic            id_jump,
  input  logic [3:0]      id_alu_op,
  input  logic [2:0]      id_funct3,
  input  logic            ex_flush,
  input  logic            mem_stall,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [4:0]      id_ex_rs1,
  output logic [4:0]      id_ex_rs2,
  output logic [4:0]      id_ex_rd,
  output logic            id_ex_uses_rs1,
  output logic            id_ex_uses_rs2,
  output logic [XLEN-1:0] id_ex_rs1_data,
  output logic [XLEN-1:0] id_ex_rs2_data,
  output logic [XLEN-1:0] id_ex_imm,
  output logic            id_ex_reg_write,
  output logic            id_ex_mem_read,
  output logic            id_ex_mem_write,
  output logic            id_ex_mem_to_reg,
  output logic            id_ex_alu_src,
  output logic            id_ex_branch,
  output logic            id_ex_jump,
  output logic [3:0]      id_ex_alu_op,
  output logic [2:0]      id_ex_funct3,
  output logic            pc_write_en,
  output logic            if_id_write_en,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] LU_INIT = 2'(LOAD_USE_BUBBLES - 1);

  lu_state_t state_q;
  logic [1:0] bcnt_q;
  ex_ctrl_t   ctrl_q;
  ex_ctrl_t   id_ctrl;
  logic       hz;
  logic       capture;
  logic       stall_bubble;

  load_use_detect u_lud (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_valid    (id_ex_valid),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (id_ex_rd),
    .hz          (hz)
  );

  assign id_ctrl = '{reg_write:  id_reg_write,  mem_read: id_mem_read,
                     mem_write:  id_mem_write,  mem_to_reg: id_mem_to_reg,
                     alu_src:    id_alu_src,    branch:   id_branch,
                     jump:       id_jump,       alu_op:   id_alu_op,
                     funct3:     id_funct3};

  // Flush outranks both stall sources, so a pending load-use stall is dropped.
  assign stall_bubble   = !ex_flush && ((state_q == ST_LU_STALL) || hz);
  assign capture        = !ex_flush && !stall_bubble;
  assign pc_write_en    = !mem_stall && !stall_bubble;
  assign if_id_write_en = !mem_stall && !stall_bubble;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      bcnt_q         <= '0;
      ctrl_q         <= CTRL_BUBBLE;
      id_ex_valid    <= 1'b0;
      id_ex_pc       <= '0;
      id_ex_rs1      <= '0;
      id_ex_rs2      <= '0;
      id_ex_rd       <= '0;
      id_ex_uses_rs1 <= 1'b0;
      id_ex_uses_rs2 <= 1'b0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_imm      <= '0;
      bubble_count   <= '0;
      flush_count    <= '0;
    end else if (!mem_stall) begin
      if (capture) begin
        ctrl_q         <= id_ctrl;
        id_ex_valid    <= id_valid;
        id_ex_pc       <= id_pc;
        id_ex_rs1      <= id_rs1;
        id_ex_rs2      <= id_rs2;
        id_ex_rd       <= id_rd;
        id_ex_uses_rs1 <= id_uses_rs1;
        id_ex_uses_rs2 <= id_uses_rs2;
        id_ex_rs1_data <= id_rs1_data;
        id_ex_rs2_data <= id_rs2_data;
        id_ex_imm      <= id_imm;
      end else begin
        ctrl_q         <= CTRL_BUBBLE;
        id_ex_valid    <= 1'b0;
        id_ex_pc       <= '0;
        id_ex_rs1      <= '0;
        id_ex_rs2      <= '0;
        id_ex_rd       <= '0;
        id_ex_uses_rs1 <= 1'b0;
        id_ex_uses_rs2 <= 1'b0;
        id_ex_rs1_data <= '0;
        id_ex_rs2_data <= '0;
        id_ex_imm      <= '0;
      end

      if (ex_flush) begin
        state_q <= ST_RUN;
        bcnt_q  <= '0;
        if (flush_count != '1) flush_count <= flush_count + 1'b1;
      end else if (stall_bubble) begin
        if (bubble_count != '1) bubble_count <= bubble_count + 1'b1;
        if (state_q == ST_LU_STALL) begin
          if (bcnt_q == 2'd1) begin
            state_q <= ST_RUN;
            bcnt_q  <= '0;
          end else begin
            bcnt_q <= bcnt_q - 1'b1;
          end
        end else if (LOAD_USE_BUBBLES > 1) begin
          state_q <= ST_LU_STALL;
          bcnt_q  <= LU_INIT;
        end
      end
    end
  end

  assign id_ex_reg_write  = ctrl_q.reg_write;
  assign id_ex_mem_read   = ctrl_q.mem_read;
  assign id_ex_mem_write  = ctrl_q.mem_write;
  assign id_ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign id_ex_alu_src    = ctrl_q.alu_src;
  assign id_ex_branch     = ctrl_q.branch;
  assign id_ex_jump       = ctrl_q.jump;
  assign id_ex_alu_op     = ctrl_q.alu_op;
  assign id_ex_funct3     = ctrl_q.funct3;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench: instance a uses three load-use bubbles, instance b one
// bubble with 2-bit counters so saturation is reachable quickly.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        id_alu_src, id_branch, id_jump;
  logic [3:0]  id_alu_op;
  logic [2:0]  id_funct3;
  logic        ex_flush, mem_stall;

  logic        a_valid, a_uses_rs1, a_uses_rs2, a_rw, a_mr, a_mw, a_m2r;
  logic        a_alu_src, a_branch, a_jump, a_pc_we, a_ifid;
  logic [31:0] a_pc, a_rs1_data, a_rs2_data, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [3:0]  a_alu_op;
  logic [2:0]  a_funct3;
  logic [15:0] a_bubble, a_flush;

  logic        b_valid, b_uses_rs1, b_uses_rs2, b_rw, b_mr, b_mw, b_m2r;
  logic        b_alu_src, b_branch, b_jump, b_pc_we, b_ifid;
  logic [31:0] b_pc, b_rs1_data, b_rs2_data, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [3:0]  b_alu_op;
  logic [2:0]  b_funct3;
  logic [1:0]  b_bubble, b_flush;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .LOAD_USE_BUBBLES(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump),
    .id_alu_op(id_alu_op), .id_funct3(id_funct3),
    .ex_flush(ex_flush), .mem_stall(mem_stall),
    .id_ex_valid(a_valid), .id_ex_pc(a_pc), .id_ex_rs1(a_rs1),
    .id_ex_rs2(a_rs2), .id_ex_rd(a_rd), .id_ex_uses_rs1(a_uses_rs1),
    .id_ex_uses_rs2(a_uses_rs2), .id_ex_rs1_data(a_rs1_data),
    .id_ex_rs2_data(a_rs2_data), .id_ex_imm(a_imm),
    .id_ex_reg_write(a_rw), .id_ex_mem_read(a_mr), .id_ex_mem_write(a_mw),
    .id_ex_mem_to_reg(a_m2r), .id_ex_alu_src(a_alu_src),
    .id_ex_branch(a_branch), .id_ex_jump(a_jump), .id_ex_alu_op(a_alu_op),
    .id_ex_funct3(a_funct3), .pc_write_en(a_pc_we), .if_id_write_en(a_ifid),
    .bubble_count(a_bubble), .flush_count(a_flush)
  );

  id_ex_stage #(.XLEN(32), .LOAD_USE_BUBBLES(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump),
    .id_alu_op(id_alu_op), .id_funct3(id_funct3),
    .ex_flush(ex_flush), .mem_stall(mem_stall),
    .id_ex_valid(b_valid), .id_ex_pc(b_pc), .id_ex_rs1(b_rs1),
    .id_ex_rs2(b_rs2), .id_ex_rd(b_rd), .id_ex_uses_rs1(b_uses_rs1),
    .id_ex_uses_rs2(b_uses_rs2), .id_ex_rs1_data(b_rs1_data),
    .id_ex_rs2_data(b_rs2_data), .id_ex_imm(b_imm),
    .id_ex_reg_write(b_rw), .id_ex_mem_read(b_mr), .id_ex_mem_write(b_mw),
    .id_ex_mem_to_reg(b_m2r), .id_ex_alu_src(b_alu_src),
    .id_ex_branch(b_branch), .id_ex_jump(b_jump), .id_ex_alu_op(b_alu_op),
    .id_ex_funct3(b_funct3), .pc_write_en(b_pc_we), .if_id_write_en(b_ifid),
    .bubble_count(b_bubble), .flush_count(b_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic u1, input logic u2, input logic rw,
                           input logic mr, input logic [3:0] op);
    id_valid      = v;
    id_pc         = pc;
    id_rd         = rd;
    id_rs1        = rs1;
    id_rs2        = rs2;
    id_uses_rs1   = u1;
    id_uses_rs2   = u2;
    id_reg_write  = rw;
    id_mem_read   = mr;
    id_mem_to_reg = mr;
    id_mem_write  = 1'b0;
    id_alu_src    = mr;
    id_branch     = 1'b0;
    id_jump       = 1'b0;
    id_alu_op     = op;
    id_funct3     = 3'b010;
    id_rs1_data   = 32'h1111_0000 | 32'(rs1);
    id_rs2_data   = 32'h2222_0000 | 32'(rs2);
    id_imm        = 32'h0000_0040;
  endtask

  initial begin
    rst_n     = 1'b0;
    ex_flush  = 1'b0;
    mem_stall = 1'b0;
    set_instr(1'b1, 32'h0, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, ALU_ADD);
    tick();
    tick();
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_rd", 32'(a_rd), 0);
    chk("rst_rw", 32'(a_rw), 0);
    chk("rst_pc_we", 32'(a_pc_we), 1);
    chk("rst_ifid", 32'(a_ifid), 1);
    chk("rst_bubble", 32'(a_bubble), 0);
    chk("rst_flush", 32'(a_flush), 0);
    chk("rst_b_valid", 32'(b_valid), 0);

    // Plain ALU instruction flows through with one cycle latency
    rst_n = 1'b1;
    set_instr(1'b1, 32'h100, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, ALU_SUB);
    tick();
    chk("alu_rd", 32'(a_rd), 5);
    chk("alu_rw", 32'(a_rw), 1);
    chk("alu_valid", 32'(a_valid), 1);
    chk("alu_pc", a_pc, 32'h100);
    chk("alu_op", 32'(a_alu_op), 32'(ALU_SUB));
    chk("alu_rs2_data", a_rs2_data, 32'h2222_0002);
    chk("alu_pc_we", 32'(a_pc_we), 1);
    chk("alu_b_rd", 32'(b_rd), 5);

    // lw x5 then add x6,x5,x7
    set_instr(1'b1, 32'h104, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, ALU_ADD);
    tick();
    set_instr(1'b1, 32'h108, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, ALU_ADD);
    #1;
    chk("lu_a_pc_we", 32'(a_pc_we), 0);
    chk("lu_a_ifid", 32'(a_ifid), 0);
    chk("lu_b_pc_we", 32'(b_pc_we), 0);
    chk("lu_b_ifid", 32'(b_ifid), 0);
    tick();
    chk("lu_e1_b_valid", 32'(b_valid), 0);
    chk("lu_e1_b_rw", 32'(b_rw), 0);
    chk("lu_e1_b_pc_we", 32'(b_pc_we), 1);
    chk("lu_e1_b_bubble", 32'(b_bubble), 1);
    chk("lu_e1_a_valid", 32'(a_valid), 0);
    chk("lu_e1_a_pc_we", 32'(a_pc_we), 0);
    chk("lu_e1_a_bubble", 32'(a_bubble), 1);
    tick();
    chk("lu_e2_b_valid", 32'(b_valid), 1);
    chk("lu_e2_b_rd", 32'(b_rd), 6);
    chk("lu_e2_a_valid", 32'(a_valid), 0);
    chk("lu_e2_a_pc_we", 32'(a_pc_we), 0);
    chk("lu_e2_a_bubble", 32'(a_bubble), 2);
    tick();
    chk("lu_e3_a_valid", 32'(a_valid), 0);
    chk("lu_e3_a_pc_we", 32'(a_pc_we), 1);
    chk("lu_e3_a_bubble", 32'(a_bubble), 3);
    tick();
    chk("lu_e4_a_valid", 32'(a_valid), 1);
    chk("lu_e4_a_rd", 32'(a_rd), 6);
    chk("lu_e4_b_bubble", 32'(b_bubble), 1);

    // Same hazard, flush arrives during the second bubble cycle
    set_instr(1'b1, 32'h10c, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, ALU_ADD);
    tick();
    set_instr(1'b1, 32'h110, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, ALU_ADD);
    tick();
    chk("fa_a_bubble", 32'(a_bubble), 4);
    chk("fa_b_bubble", 32'(b_bubble), 2);
    chk("fa_a_pc_we_stall", 32'(a_pc_we), 0);
    ex_flush = 1'b1;
    #1;
    chk("fa_a_pc_we", 32'(a_pc_we), 1);
    chk("fa_a_ifid", 32'(a_ifid), 1);
    tick();
    chk("fa_a_flush", 32'(a_flush), 1);
    chk("fa_a_bubble_hold", 32'(a_bubble), 4);
    chk("fa_a_valid", 32'(a_valid), 0);
    chk("fa_b_flush", 32'(b_flush), 1);
    ex_flush = 1'b0;
    #1;
    chk("fa_a_pc_we_run", 32'(a_pc_we), 1);
    tick();
    chk("fa_a_rd", 32'(a_rd), 6);
    chk("fa_a_valid_cap", 32'(a_valid), 1);

    // Memory stall freezes everything, including a concurrent flush
    set_instr(1'b1, 32'h200, 5'd9, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, ALU_OR);
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ex_flush = (i == 1);
      #1;
      chk("ms_pc_we", 32'(a_pc_we), 0);
      chk("ms_ifid", 32'(a_ifid), 0);
      tick();
      chk("ms_rd", 32'(a_rd), 6);
      chk("ms_valid", 32'(a_valid), 1);
      chk("ms_pc", a_pc, 32'h110);
      chk("ms_flush", 32'(a_flush), 1);
    end
    mem_stall = 1'b0;
    ex_flush  = 1'b1;
    tick();
    chk("ms_post_valid", 32'(a_valid), 0);
    chk("ms_post_rw", 32'(a_rw), 0);
    chk("ms_post_rd", 32'(a_rd), 0);
    chk("ms_post_alu_op", 32'(a_alu_op), 0);
    chk("ms_post_flush", 32'(a_flush), 2);
    chk("ms_post_b_flush", 32'(b_flush), 2);
    ex_flush = 1'b0;

    // lw x0 followed by a read of x0
    set_instr(1'b1, 32'h300, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, ALU_ADD);
    tick();
    set_instr(1'b1, 32'h304, 5'd6, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, ALU_ADD);
    #1;
    chk("x0_pc_we", 32'(a_pc_we), 1);
    tick();
    chk("x0_valid", 32'(a_valid), 1);
    chk("x0_rs1", 32'(a_rs1), 0);
    chk("x0_bubble", 32'(a_bubble), 4);

    // lw x5 followed by lui x5 (rs fields match but are not read)
    set_instr(1'b1, 32'h308, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, ALU_ADD);
    tick();
    set_instr(1'b1, 32'h30c, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, ALU_LUI);
    #1;
    chk("lui_a_pc_we", 32'(a_pc_we), 1);
    chk("lui_b_pc_we", 32'(b_pc_we), 1);
    tick();
    chk("lui_rd", 32'(a_rd), 5);
    chk("lui_mr", 32'(a_mr), 0);
    chk("lui_alu_op", 32'(a_alu_op), 32'(ALU_LUI));
    chk("lui_bubble", 32'(a_bubble), 4);
    chk("lui_b_bubble", 32'(b_bubble), 2);

    // Matching source but ID slot empty: no hazard
    set_instr(1'b1, 32'h310, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, ALU_ADD);
    tick();
    set_instr(1'b0, 32'h314, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, ALU_ADD);
    #1;
    chk("inv_pc_we", 32'(a_pc_we), 1);
    tick();
    chk("inv_valid", 32'(a_valid), 0);
    chk("inv_bubble", 32'(a_bubble), 4);

    // Two more hazards: b's 2-bit bubble counter saturates at 3
    for (int k = 0; k < 2; k++) begin
      set_instr(1'b1, 32'h400, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, ALU_ADD);
      tick();
      set_instr(1'b1, 32'h404, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, ALU_ADD);
      repeat (4) tick();
      chk("sat_b_bubble", 32'(b_bubble), 3);
      chk("sat_a_bubble", 32'(a_bubble), (k == 0) ? 7 : 10);
    end

    ex_flush = 1'b1;
    tick();
    tick();
    ex_flush = 1'b0;
    chk("sat_b_flush", 32'(b_flush), 3);
    chk("sat_a_flush", 32'(a_flush), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
